// File: rtl/stopwatch_pkg.sv
// Shared state encoding and width helpers for the lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } sw_state_t;

    // Address/counter width for n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ enabled clocks; phase holds while en is low.
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
    localparam int PW  = width_of(DIV);
    localparam logic [PW-1:0] TC = PW'(DIV - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == TC) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Up/down stopwatch with optional lap memory (enabled by defining LAP_STOPWATCH_LAP_MEM_EN).
//   state   | meaning
//   IDLE    | cleared, mode follows the input, waiting for start
//   RUN     | counting on every prescaler tick
//   PAUSE   | count and prescaler phase frozen
//   EXPIRED | countdown reached zero, only clear/rst leave
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_CNT = 100_000_000,
    parameter int LAPS    = 4,
    localparam int CW  = width_of(MAX_CNT),
    localparam int LSW = width_of(LAPS),
    localparam int LCW = width_of(LAPS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_stop,
    input  logic           clear,
    input  logic           lap,
    input  logic           mode,
    input  logic [CW-1:0]  load_cnt,
    input  logic [LSW-1:0] lap_sel,
    output logic [CW-1:0]  count,
    output logic [CW-1:0]  lap_data,
    output logic [LCW-1:0] lap_count,
    output logic           running,
    output logic           expired,
    output logic           lap_full,
    output logic           wrap_pulse
);

    localparam logic [CW-1:0] CMAX = CW'(MAX_CNT - 1);

    sw_state_t     state;
    logic          mode_l;
    logic          tick;
    logic          tick_en;
    logic [CW-1:0] load_clamp;

    assign load_clamp = (load_cnt > CMAX) ? CMAX : load_cnt;
    // A stop pulse freezes the prescaler in the same cycle so no tick is lost across a pause.
    assign tick_en    = (state == RUN) && !clear && !start_stop;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (clear),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            mode_l     <= 1'b0;
            running    <= 1'b0;
            expired    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
                expired <= 1'b0;
                mode_l  <= mode;
                count   <= mode ? load_clamp : '0;
            end else begin
                case (state)
                    IDLE: begin
                        mode_l <= mode;
                        if (start_stop && !(mode && (count == '0))) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            if (!mode_l) begin
                                if (count == CMAX) begin
                                    count      <= '0;
                                    wrap_pulse <= 1'b1;
                                end else begin
                                    count <= count + 1'b1;
                                end
                            end else if ((count == CW'(1)) || (count == '0)) begin
                                count   <= '0;
                                state   <= EXPIRED;
                                running <= 1'b0;
                                expired <= 1'b1;
                            end else begin
                                count <= count - 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LAP_STOPWATCH_LAP_MEM_EN
    logic [CW-1:0] lap_mem [LAPS];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < LAPS; i++) lap_mem[i] <= '0;
            lap_count <= '0;
            lap_full  <= 1'b0;
        end else if (lap && ((state == RUN) || (state == PAUSE)) && !lap_full) begin
            lap_mem[lap_count[LSW-1:0]] <= count;
            lap_count <= lap_count + 1'b1;
            lap_full  <= (lap_count == LCW'(LAPS - 1));
        end
    end

    assign lap_data = (LCW'(lap_sel) < lap_count) ? lap_mem[lap_sel] : '0;
`else
    logic unused_lap;

    assign unused_lap = ^{lap, lap_sel};
    assign lap_data   = '0;
    assign lap_count  = '0;
    assign lap_full   = 1'b0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised and directed checks of lap_stopwatch against an arithmetic reference model.
module tb_lap_stopwatch;

`ifdef LAP_STOPWATCH_LAP_MEM_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam int DIV  = 10;
    localparam int MAXC = 1000;
    localparam int NL   = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic       clk = 1'b0;
    logic       rst, start_stop, clear, lap, mode;
    logic [9:0] load_cnt, count, lap_data;
    logic [1:0] lap_sel;
    logic [2:0] lap_count;
    logic       running, expired, lap_full, wrap_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    int ms, m_count, m_phase, m_mode;
    int m_laps[$];

    lap_stopwatch #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .MAX_CNT(1000),
        .LAPS   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .mode      (mode),
        .load_cnt  (load_cnt),
        .lap_sel   (lap_sel),
        .count     (count),
        .lap_data  (lap_data),
        .lap_count (lap_count),
        .running   (running),
        .expired   (expired),
        .lap_full  (lap_full),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed running time converts to whole ticks arithmetically.
    task automatic model_advance(input int n);
        int total, ticks;
        if (ms != S_RUN) return;
        total   = m_phase + n;
        ticks   = total / DIV;
        m_phase = total % DIV;
        if (m_mode == 0) begin
            m_count = (m_count + ticks) % MAXC;
        end else if (ticks >= m_count) begin
            m_count = 0;
            ms      = S_EXP;
        end else begin
            m_count = m_count - ticks;
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; m_count = 0; m_phase = 0; m_mode = 0;
        m_laps.delete();
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        model_advance(n);
    endtask

    task automatic press_start();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        case (ms)
            S_IDLE:  if (!(m_mode == 1 && m_count == 0)) ms = S_RUN;
            S_RUN:   ms = S_PAUSE;
            S_PAUSE: ms = S_RUN;
            default: ;
        endcase
    endtask

    task automatic press_clear(input int new_mode, input int new_load);
        mode     = new_mode[0];
        load_cnt = 10'(new_load);
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        ms       = S_IDLE;
        m_mode   = new_mode;
        m_count  = (new_mode != 0) ? ((new_load > MAXC - 1) ? MAXC - 1 : new_load) : 0;
        m_phase  = 0;
        m_laps.delete();
    endtask

    task automatic press_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        if (LAP_EN && (ms == S_RUN || ms == S_PAUSE) && m_laps.size() < NL) m_laps.push_back(m_count);
        model_advance(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        lap_sel = 2'd0;
        #1;
        n_tests++; if (count !== 10'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (running !== 1'b0 || expired !== 1'b0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got run=%b exp=%b wrap=%b expected 0 0 0", running, expired, wrap_pulse); end
        n_tests++; if (lap_count !== 3'd0 || lap_full !== 1'b0 || lap_data !== 10'd0) begin n_fail++; $display("FAIL reset_laps: got cnt=%0d full=%b data=%0d expected 0 0 0", lap_count, lap_full, lap_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_pause();
        press_clear(0, 0);
        press_start();
        run(505);
        n_tests++; if (count !== 10'd50 || running !== 1'b1) begin n_fail++; $display("FAIL run_50: got count=%0d run=%b expected 50 1", count, running); end
        press_start();
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", running); end
        run(1000);
        n_tests++; if (count !== 10'd50) begin n_fail++; $display("FAIL pause_hold: got %0d expected 50", count); end
        press_start();
        run(4);
        n_tests++; if (count !== 10'd50) begin n_fail++; $display("FAIL phase_hold_pre: got %0d expected 50", count); end
        run(1);
        n_tests++; if (count !== 10'd51) begin n_fail++; $display("FAIL phase_hold_tick: got %0d expected 51", count); end
    endtask

    task automatic test_wrap();
        press_clear(0, 0);
        press_start();
        run(9990);
        n_tests++; if (count !== 10'd999) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 999", count); end
        run(9);
        n_tests++; if (count !== 10'd999 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_hold: got count=%0d wrap=%b expected 999 0", count, wrap_pulse); end
        run(1);
        n_tests++; if (count !== 10'd0 || wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_edge: got count=%0d wrap=%b expected 0 1", count, wrap_pulse); end
        run(1);
        n_tests++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle: got %b expected 0", wrap_pulse); end
    endtask

    task automatic test_countdown();
        press_clear(1, 3);
        n_tests++; if (count !== 10'd3) begin n_fail++; $display("FAIL down_load: got %0d expected 3", count); end
        press_start();
        run(29);
        n_tests++; if (count !== 10'd1 || expired !== 1'b0) begin n_fail++; $display("FAIL down_pre: got count=%0d exp=%b expected 1 0", count, expired); end
        run(1);
        n_tests++; if (count !== 10'd0 || expired !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL down_expire: got count=%0d exp=%b run=%b expected 0 1 0", count, expired, running); end
        press_start();
        run(20);
        n_tests++; if (running !== 1'b0 || expired !== 1'b1 || count !== 10'd0) begin n_fail++; $display("FAIL expired_ignore_start: got run=%b exp=%b count=%0d expected 0 1 0", running, expired, count); end
        press_clear(1, 0);
        press_start();
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL down_zero_start: got %b expected 0", running); end
        press_clear(1, 1023);
        n_tests++; if (count !== 10'd999) begin n_fail++; $display("FAIL down_clamp: got %0d expected 999", count); end
    endtask

    task automatic test_laps();
        press_clear(0, 0);
        press_start();
        for (int i = 0; i < 5; i++) begin
            run((i == 0) ? 100 : 99);
            press_lap();
        end
        n_tests++; if (lap_count !== (LAP_EN ? 3'd4 : 3'd0) || lap_full !== LAP_EN) begin n_fail++; $display("FAIL laps_full: got cnt=%0d full=%b expected %0d %b", lap_count, lap_full, LAP_EN ? 4 : 0, LAP_EN); end
        for (int i = 0; i < 4; i++) begin
            lap_sel = 2'(i);
            #1;
            n_tests++; if (lap_data !== (LAP_EN ? 10'(10 * (i + 1)) : 10'd0)) begin n_fail++; $display("FAIL lap_data%0d: got %0d expected %0d", i, lap_data, LAP_EN ? 10 * (i + 1) : 0); end
        end
    endtask

    task automatic test_back_to_back();
        press_clear(0, 0);
        press_start();
        run(70);
        lap = 1'b1; start_stop = 1'b1;
        @(negedge clk);
        lap = 1'b0; start_stop = 1'b0;
        if (LAP_EN) m_laps.push_back(m_count);
        ms = S_PAUSE;
        lap_sel = 2'd0;
        #1;
        n_tests++; if (running !== 1'b0 || lap_count !== (LAP_EN ? 3'd1 : 3'd0) || lap_data !== (LAP_EN ? 10'd7 : 10'd0)) begin n_fail++; $display("FAIL lap_with_stop: got run=%b cnt=%0d data=%0d expected 0 %0d %0d", running, lap_count, lap_data, LAP_EN ? 1 : 0, LAP_EN ? 7 : 0); end
        lap_sel = 2'd1;
        #1;
        n_tests++; if (lap_data !== 10'd0) begin n_fail++; $display("FAIL lap_sel_beyond: got %0d expected 0", lap_data); end
        press_start();
        run(30);
        clear = 1'b1; start_stop = 1'b1;
        @(negedge clk);
        clear = 1'b0; start_stop = 1'b0;
        ms = S_IDLE; m_count = 0; m_phase = 0; m_laps.delete();
        run(25);
        n_tests++; if (running !== 1'b0 || count !== 10'd0 || lap_count !== 3'd0) begin n_fail++; $display("FAIL clear_with_start: got run=%b count=%0d laps=%0d expected 0 0 0", running, count, lap_count); end
    endtask

    task automatic test_rst_mid_run();
        press_clear(0, 0);
        press_start();
        run(500);
        press_lap();
        press_lap();
        run(729);
        n_tests++; if (count !== 10'd123 || lap_count !== (LAP_EN ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL rst_pre: got count=%0d laps=%0d expected 123 %0d", count, lap_count, LAP_EN ? 2 : 0); end
        run(6);
        rst = 1'b1; lap = 1'b1;
        @(negedge clk);
        model_reset();
        lap_sel = 2'd0;
        #1;
        n_tests++; if (count !== 10'd0 || running !== 1'b0 || expired !== 1'b0 || wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid_run: got count=%0d run=%b exp=%b wrap=%b expected 0 0 0 0", count, running, expired, wrap_pulse); end
        n_tests++; if (lap_count !== 3'd0 || lap_full !== 1'b0 || lap_data !== 10'd0) begin n_fail++; $display("FAIL rst_mid_laps: got cnt=%0d full=%b data=%0d expected 0 0 0", lap_count, lap_full, lap_data); end
        rst = 1'b0; lap = 1'b0; mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int op, sel, exp_data;
        press_clear(0, 0);
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 3)      run($urandom_range(1, 60));
            else if (op <= 5) press_start();
            else if (op <= 7) press_lap();
            else if (op == 8) press_clear($urandom_range(0, 1),
                                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 12));
            else if (ms != S_IDLE) begin
                mode = ~mode;
                run(1);
            end else run(1);
            sel = $urandom_range(0, 3);
            lap_sel = 2'(sel);
            exp_data = (sel < m_laps.size()) ? m_laps[sel] : 0;
            #1;
            n_tests++; if (count !== 10'(m_count)) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, count, m_count); end
            n_tests++; if (running !== (ms == S_RUN) || expired !== (ms == S_EXP)) begin n_fail++; $display("FAIL rand_state[%0d]: got run=%b exp=%b expected state %0d", k, running, expired, ms); end
            n_tests++; if (lap_count !== 3'(m_laps.size()) || lap_full !== (m_laps.size() == NL) || lap_data !== 10'(exp_data)) begin n_fail++; $display("FAIL rand_laps[%0d]: got cnt=%0d full=%b data=%0d expected %0d %0d", k, lap_count, lap_full, lap_data, m_laps.size(), exp_data); end
        end
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; mode = 1'b0;
        load_cnt = '0; lap_sel = '0;
        model_reset();
        test_reset();
        test_run_pause();
        test_wrap();
        test_countdown();
        test_laps();
        test_back_to_back();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
